// File: rtl/uart_bridge_pkg.sv
// Shared definitions for the UART <-> command/reply FIFO bridge blocks.
// Used by uart_rx_to_fifo and uart_tx_from_fifo.
package uart_bridge_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Saturating increment: never exceeds max_value, never wraps.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? max_value : value + 32'd1;
    endfunction

endpackage

// File: rtl/uart_rx_to_fifo.sv
// Moves bytes from uart_rx into the command FIFO through a small holding buffer,
// tracking drop/framing-error status and flagging the end of a frame after line idle.
module uart_rx_to_fifo
    import uart_bridge_pkg::*;
#(
    parameter int unsigned HOLD_DEPTH  = 4,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDLE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             rx_frame_err,
    input  logic             fifo_full,
    output logic             fifo_wr_en,
    output logic [7:0]       fifo_wr_data,
    output logic             frame_end,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] err_count,
    input  logic             clear_status
);

    localparam int unsigned IDX_W  = $clog2(HOLD_DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned IDLE_W = $clog2(IDLE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_CYCLES);

    byte_t             mem [HOLD_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              buf_empty;
    logic              buf_full;
    logic              good_byte;
    logic              push;
    logic              pop;
    logic              drop;
    logic              bad_byte;
    logic              armed;
    logic [IDLE_W-1:0] idle_cnt;
    logic [CNT_W-1:0]  drop_base;
    logic [CNT_W-1:0]  err_base;

    assign buf_empty = (wr_ptr == rd_ptr);
    assign buf_full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) && (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);

    assign fifo_wr_en   = !buf_empty && !fifo_full;
    assign fifo_wr_data = buf_empty ? '0 : mem[rd_ptr[IDX_W-1:0]];

    assign pop       = fifo_wr_en;
    assign good_byte = rx_valid && !rx_frame_err;
    assign bad_byte  = rx_valid && rx_frame_err;
    assign push      = good_byte && (!buf_full || pop);
    assign drop      = good_byte && buf_full && !pop;

    // A concurrent clear takes effect first, so a same-cycle event counts from zero.
    assign drop_base = clear_status ? '0 : drop_count;
    assign err_base  = clear_status ? '0 : err_count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            err_count  <= '0;
        end else begin
            overflow   <= (overflow && !clear_status) || drop;
            drop_count <= drop ? CNT_W'(sat_inc(32'(drop_base), 32'(CNT_MAX))) : drop_base;
            err_count  <= bad_byte ? CNT_W'(sat_inc(32'(err_base), 32'(CNT_MAX))) : err_base;
        end
    end

    // idle_cnt counts cycles since the last rx_valid, the rx_valid cycle itself being 1,
    // so frame_end lands exactly IDLE_CYCLES cycles after the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt  <= '0;
            armed     <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (rx_valid) begin
                idle_cnt <= IDLE_W'(1);
                if (push) begin
                    armed <= 1'b1;
                end
            end else if (armed) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_cnt + IDLE_W'(1) == IDLE_LIMIT) begin
                    frame_end <= 1'b1;
                    armed     <= 1'b0;
                end
            end
        end
    end

endmodule
